// File: rtl/wt_mem_arbiter_pkg.sv
// Shared types for the write-through cache memory arbiter: request payloads,
// the combined arbiter request word and the arbiter FSM states.
package wt_cache_pkg;

    localparam int ARB_CNT_W = 4;

    localparam logic SRC_IC = 1'b0;
    localparam logic SRC_DC = 1'b1;

    typedef struct packed {
        logic [31:0] paddr;
        logic        nc;
    } icache_req_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic [63:0] wdata;
        logic [1:0]  size;
        logic        we;
    } dcache_req_t;

    typedef struct packed {
        logic        src;
        icache_req_t ic;
        dcache_req_t dc;
    } wt_arb_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wt_mem_arbiter_txn_cnt.sv
// Per-source outstanding transaction counter. Increments on accepted requests,
// decrements on returns, saturating at zero.
module wt_arb_txn_cnt
    import wt_cache_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_empty
);

    logic [ARB_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_full  = (r_cnt == ARB_CNT_W'(MaxOutstanding));
    assign o_empty = (r_cnt == '0);

    // A return with nothing outstanding means the adapter lost track of a source.
    a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_dec && o_empty));

endmodule

// File: rtl/wt_mem_arbiter.sv
// Arbitrates I$/D$ requests onto one registered valid/ready memory port, tracks
// outstanding transactions per source and drains them for a D$ flush.
// Optional grant counters are enabled with `define WT_ARB_PERF_CNT_EN.
module wt_mem_arbiter
    import wt_cache_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter bit          IcachePrio     = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    output logic        flush_ack_o,
    input  logic        icache_data_req_i,
    output logic        icache_data_ack_o,
    input  icache_req_t icache_data_i,
    input  logic        dcache_data_req_i,
    output logic        dcache_data_ack_o,
    input  dcache_req_t dcache_data_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output wt_arb_req_t mem_req_o,
    input  logic        mem_rtrn_vld_i,
    input  logic        mem_rtrn_src_i,
    output logic        icache_rtrn_vld_o,
    output logic        dcache_rtrn_vld_o,
`ifdef WT_ARB_PERF_CNT_EN
    output logic [31:0] icache_grant_cnt_o,
    output logic [31:0] dcache_grant_cnt_o,
`endif
    output logic        busy_o
);

    arb_state_e  r_state;
    wt_arb_req_t r_req;
    logic        r_rr_ptr;
    logic        r_flush_ack;
    logic        r_flush_done;

    logic w_ic_full, w_dc_full, w_ic_empty, w_dc_empty;
    logic w_ic_elig, w_dc_elig, w_grant, w_grant_src;
    logic w_accept, w_rtrn_ic, w_rtrn_dc;

    assign w_ic_elig = icache_data_req_i & ~w_ic_full & ~flush_i;
    assign w_dc_elig = dcache_data_req_i & ~w_dc_full & ~flush_i;

    always_comb begin
        w_grant_src = SRC_IC;
        if (w_ic_elig && w_dc_elig) begin
            w_grant_src = IcachePrio ? SRC_IC : r_rr_ptr;
        end else if (w_dc_elig) begin
            w_grant_src = SRC_DC;
        end
    end

    // Acks are combinational in the grant cycle; masking with reset keeps
    // every output low while reset is held.
    assign w_grant   = rst_ni & (r_state == IDLE) & (w_ic_elig | w_dc_elig);
    assign w_accept  = (r_state == HOLD) & mem_req_ready_i;
    assign w_rtrn_ic = rst_ni & mem_rtrn_vld_i & ~mem_rtrn_src_i;
    assign w_rtrn_dc = rst_ni & mem_rtrn_vld_i & mem_rtrn_src_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_req        <= '0;
            r_rr_ptr     <= SRC_IC;
            r_flush_ack  <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_ack <= 1'b0;
            if (!flush_i) r_flush_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // After a completed drain, a still-high flush only blocks grants.
                    if (flush_i && !r_flush_done) begin
                        r_state <= DRAIN;
                    end else if (w_grant) begin
                        r_state   <= HOLD;
                        r_req.src <= w_grant_src;
                        r_req.ic  <= icache_data_i;
                        r_req.dc  <= dcache_data_i;
                        r_rr_ptr  <= ~w_grant_src;
                    end
                end
                HOLD: begin
                    if (mem_req_ready_i) begin
                        r_state <= (flush_i && !r_flush_done) ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (w_ic_empty && w_dc_empty) begin
                        r_state      <= IDLE;
                        r_flush_ack  <= 1'b1;
                        r_flush_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    wt_arb_txn_cnt #(.MaxOutstanding(MaxOutstanding)) u_cnt_ic (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_inc   (w_accept & (r_req.src == SRC_IC)),
        .i_dec   (w_rtrn_ic),
        .o_full  (w_ic_full),
        .o_empty (w_ic_empty)
    );

    wt_arb_txn_cnt #(.MaxOutstanding(MaxOutstanding)) u_cnt_dc (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_inc   (w_accept & (r_req.src == SRC_DC)),
        .i_dec   (w_rtrn_dc),
        .o_full  (w_dc_full),
        .o_empty (w_dc_empty)
    );

`ifdef WT_ARB_PERF_CNT_EN
    logic [31:0] r_ic_gcnt, r_dc_gcnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ic_gcnt <= '0;
            r_dc_gcnt <= '0;
        end else if (w_accept) begin
            if (r_req.src == SRC_IC) r_ic_gcnt <= r_ic_gcnt + 32'd1;
            else                     r_dc_gcnt <= r_dc_gcnt + 32'd1;
        end
    end

    assign icache_grant_cnt_o = r_ic_gcnt;
    assign dcache_grant_cnt_o = r_dc_gcnt;
`endif

    assign icache_data_ack_o = w_grant & (w_grant_src == SRC_IC);
    assign dcache_data_ack_o = w_grant & (w_grant_src == SRC_DC);
    assign mem_req_valid_o   = (r_state == HOLD);
    assign mem_req_o         = r_req;
    assign flush_ack_o       = r_flush_ack;
    assign icache_rtrn_vld_o = w_rtrn_ic;
    assign dcache_rtrn_vld_o = w_rtrn_dc;
    assign busy_o            = (r_state != IDLE) | ~w_ic_empty | ~w_dc_empty;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Directed table-driven bench for wt_mem_arbiter: a round-robin instance and a
// fixed-I$-priority instance run on shared stimulus.
module tb_wt_mem_arbiter;
    import wt_cache_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        flush, ic_req, dc_req, rdy, rv, rs;
    icache_req_t ic_data;
    dcache_req_t dc_data;

    logic        fack, ic_ack, dc_ack, vld, icr, dcr, busy;
    wt_arb_req_t req;
    logic        p_fack, p_ic_ack, p_dc_ack, p_vld, p_icr, p_dcr, p_busy;
    wt_arb_req_t p_req;

    wt_mem_arbiter #(.MaxOutstanding(4), .IcachePrio(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .flush_ack_o(fack),
        .icache_data_req_i(ic_req), .icache_data_ack_o(ic_ack), .icache_data_i(ic_data),
        .dcache_data_req_i(dc_req), .dcache_data_ack_o(dc_ack), .dcache_data_i(dc_data),
        .mem_req_valid_o(vld), .mem_req_ready_i(rdy), .mem_req_o(req),
        .mem_rtrn_vld_i(rv), .mem_rtrn_src_i(rs),
        .icache_rtrn_vld_o(icr), .dcache_rtrn_vld_o(dcr), .busy_o(busy)
    );

    wt_mem_arbiter #(.MaxOutstanding(4), .IcachePrio(1'b1)) dut_p (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .flush_ack_o(p_fack),
        .icache_data_req_i(ic_req), .icache_data_ack_o(p_ic_ack), .icache_data_i(ic_data),
        .dcache_data_req_i(dc_req), .dcache_data_ack_o(p_dc_ack), .dcache_data_i(dc_data),
        .mem_req_valid_o(p_vld), .mem_req_ready_i(rdy), .mem_req_o(p_req),
        .mem_rtrn_vld_i(rv), .mem_rtrn_src_i(rs),
        .icache_rtrn_vld_o(p_icr), .dcache_rtrn_vld_o(p_dcr), .busy_o(p_busy)
    );

    typedef struct {
        logic rst, ic, dc, rdy, rv, rs, fl;
        logic ica, dca, vld, src, icr, dcr, fa, busy, pica, pdca;
    } vec_t;

    vec_t vq[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic add(input logic rst_, ic_, dc_, rdy_, rv_, rs_, fl_,
                       input logic ica_, dca_, vld_, src_, icr_, dcr_, fa_, busy_,
                       input logic pica_, pdca_);
        vec_t v;
        v = '{rst_, ic_, dc_, rdy_, rv_, rs_, fl_,
              ica_, dca_, vld_, src_, icr_, dcr_, fa_, busy_, pica_, pdca_};
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rst_row();
        add(1, 0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0);
    endtask

    // Three back-to-back I$ requests with ready held high.
    task automatic ic_three(input logic first_busy);
        add(0, 1,0,1,0,0,0, 1,0,0,0,0,0,0,first_busy, 1,0);
        add(0, 1,0,1,0,0,0, 0,0,1,0,0,0,0,1, 0,0);
        for (int k = 0; k < 2; k++) begin
            add(0, 1,0,1,0,0,0, 1,0,0,0,0,0,0,1, 1,0);
            add(0, 1,0,1,0,0,0, 0,0,1,0,0,0,0,1, 0,0);
        end
    endtask

    logic [31:0] epa_ic, epa_dc;
    int          first_ack, n_pulse, n_bad_ack;

    initial begin
        {flush, ic_req, dc_req, rdy, rv, rs} = '0;
        ic_data = '0;
        dc_data = '0;
        epa_ic  = '0;
        epa_dc  = '0;

        // Reset state, then I$-only traffic; busy at the last return shows 3 were counted.
        rst_row();
        ic_three(0);
        add(0, 0,0,1,1,0,0, 0,0,0,0,1,0,0,1, 0,0);
        add(0, 0,0,1,1,0,0, 0,0,0,0,1,0,0,1, 0,0);
        add(0, 0,0,1,1,0,0, 0,0,0,0,1,0,0,1, 0,0);
        add(0, 0,0,1,0,0,0, 0,0,0,0,0,0,0,0, 0,0);

        // Both request: round-robin alternates, fixed priority stays on I$ until full.
        rst_row();
        add(0, 1,1,1,0,0,0, 1,0,0,0,0,0,0,0, 1,0);
        add(0, 1,1,1,0,0,0, 0,0,1,0,0,0,0,1, 0,0);
        add(0, 1,1,1,0,0,0, 0,1,0,0,0,0,0,1, 1,0);
        add(0, 1,1,1,0,0,0, 0,0,1,1,0,0,0,1, 0,0);
        add(0, 1,1,1,0,0,0, 1,0,0,0,0,0,0,1, 1,0);
        add(0, 1,1,1,0,0,0, 0,0,1,0,0,0,0,1, 0,0);
        add(0, 1,1,1,0,0,0, 0,1,0,0,0,0,0,1, 1,0);
        add(0, 1,1,1,0,0,0, 0,0,1,1,0,0,0,1, 0,0);
        add(0, 1,1,1,0,0,0, 1,0,0,0,0,0,0,1, 0,1);
        add(0, 1,1,1,0,0,0, 0,0,1,0,0,0,0,1, 0,0);

        // D$ fills to 4; I$ still granted; one return frees a slot; return+accept nets zero.
        rst_row();
        add(0, 0,1,1,0,0,0, 0,1,0,0,0,0,0,0, 0,1);
        add(0, 0,1,1,0,0,0, 0,0,1,1,0,0,0,1, 0,0);
        for (int k = 0; k < 3; k++) begin
            add(0, 0,1,1,0,0,0, 0,1,0,0,0,0,0,1, 0,1);
            add(0, 0,1,1,0,0,0, 0,0,1,1,0,0,0,1, 0,0);
        end
        add(0, 1,1,1,0,0,0, 1,0,0,0,0,0,0,1, 1,0);
        add(0, 0,1,1,0,0,0, 0,0,1,0,0,0,0,1, 0,0);
        add(0, 0,1,1,1,1,0, 0,0,0,0,0,1,0,1, 0,0);
        add(0, 0,1,1,0,0,0, 0,1,0,0,0,0,0,1, 0,1);
        add(0, 0,1,1,1,1,0, 0,0,1,1,0,1,0,1, 0,0);
        add(0, 0,1,1,0,0,0, 0,1,0,0,0,0,0,1, 0,1);
        add(0, 0,1,1,0,0,0, 0,0,1,1,0,0,0,1, 0,0);
        add(0, 0,1,1,0,0,0, 0,0,0,0,0,0,0,1, 0,0);

        // Flush with 2 outstanding and one request held by ready=0.
        rst_row();
        add(0, 1,0,1,0,0,0, 1,0,0,0,0,0,0,0, 1,0);
        add(0, 1,0,1,0,0,0, 0,0,1,0,0,0,0,1, 0,0);
        add(0, 1,0,1,0,0,0, 1,0,0,0,0,0,0,1, 1,0);
        add(0, 1,0,1,0,0,0, 0,0,1,0,0,0,0,1, 0,0);
        add(0, 1,0,0,0,0,0, 1,0,0,0,0,0,0,1, 1,0);
        add(0, 1,0,0,0,0,1, 0,0,1,0,0,0,0,1, 0,0);
        add(0, 1,0,0,0,0,1, 0,0,1,0,0,0,0,1, 0,0);
        add(0, 1,0,1,0,0,1, 0,0,1,0,0,0,0,1, 0,0);
        for (int k = 0; k < 3; k++) add(0, 1,0,1,1,0,1, 0,0,0,0,1,0,0,1, 0,0);
        add(0, 1,0,1,0,0,1, 0,0,0,0,0,0,0,1, 0,0);
        add(0, 1,0,1,0,0,1, 0,0,0,0,0,0,1,0, 0,0);
        add(0, 1,0,1,0,0,1, 0,0,0,0,0,0,0,0, 0,0);
        add(0, 1,0,1,0,0,0, 1,0,0,0,0,0,0,0, 1,0);
        add(0, 0,0,1,0,0,0, 0,0,1,0,0,0,0,1, 0,0);

        // Reset while holding with 3 outstanding.
        rst_row();
        ic_three(0);
        add(0, 1,0,0,0,0,0, 1,0,0,0,0,0,0,1, 1,0);
        add(0, 1,0,0,0,0,0, 0,0,1,0,0,0,0,1, 0,0);
        add(1, 1,1,1,1,0,1, 0,0,0,0,0,0,0,0, 0,0);
        add(0, 0,0,1,0,0,0, 0,0,0,0,0,0,0,0, 0,0);
        add(0, 1,0,1,0,0,0, 1,0,0,0,0,0,0,0, 1,0);
        add(0, 0,0,1,0,0,0, 0,0,1,0,0,0,0,1, 0,0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst_n   = ~vq[i].rst;
            ic_req  = vq[i].ic;
            dc_req  = vq[i].dc;
            rdy     = vq[i].rdy;
            rv      = vq[i].rv;
            rs      = vq[i].rs;
            flush   = vq[i].fl;
            ic_data = '{paddr: 32'h1000 + 32'(i), nc: 1'b0};
            dc_data = '{paddr: 32'h2000 + 32'(i), wdata: 64'(i), size: 2'd3, we: 1'b1};
            #1;
            chk($sformatf("r%0d ic_ack", i), ic_ack, vq[i].ica);
            chk($sformatf("r%0d dc_ack", i), dc_ack, vq[i].dca);
            chk($sformatf("r%0d valid", i), vld, vq[i].vld);
            chk($sformatf("r%0d ic_rtrn", i), icr, vq[i].icr);
            chk($sformatf("r%0d dc_rtrn", i), dcr, vq[i].dcr);
            chk($sformatf("r%0d flush_ack", i), fack, vq[i].fa);
            chk($sformatf("r%0d busy", i), busy, vq[i].busy);
            chk($sformatf("r%0d prio ic_ack", i), p_ic_ack, vq[i].pica);
            chk($sformatf("r%0d prio dc_ack", i), p_dc_ack, vq[i].pdca);
            chk($sformatf("r%0d prio valid", i), p_vld, vq[i].vld);
            chk($sformatf("r%0d prio ic_rtrn", i), p_icr, vq[i].icr);
            chk($sformatf("r%0d prio dc_rtrn", i), p_dcr, vq[i].dcr);
            chk($sformatf("r%0d prio flush_ack", i), p_fack, vq[i].fa);
            chk($sformatf("r%0d prio busy", i), p_busy, vq[i].busy);
            if (vq[i].rst) chk($sformatf("r%0d req in reset", i), 32'(req.ic.paddr), 32'h0);
            if (vq[i].ica || vq[i].dca) begin
                epa_ic = 32'h1000 + 32'(i);
                epa_dc = 32'h2000 + 32'(i);
            end
            if (vq[i].vld) begin
                chk($sformatf("r%0d src", i), 32'(req.src), 32'(vq[i].src));
                chk($sformatf("r%0d ic paddr", i), req.ic.paddr, epa_ic);
                chk($sformatf("r%0d dc paddr", i), req.dc.paddr, epa_dc);
            end
        end

        // Flush drain with a bounded wait on flush_ack and D$ held requesting throughout.
        @(negedge clk);
        rst_n = 1'b0;
        {flush, ic_req, dc_req, rv, rs} = '0;
        rdy = 1'b1;
        @(negedge clk);
        rst_n  = 1'b1;
        dc_req = 1'b1;
        #1 chk("seq dc_ack", dc_ack, 1);
        @(negedge clk);
        #1 chk("seq valid", vld, 1);
        first_ack = -1;
        n_pulse   = 0;
        n_bad_ack = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            flush = 1'b1;
            rv    = (cyc == 3);
            rs    = 1'b1;
            #1;
            if (fack && first_ack < 0) first_ack = cyc;
            if (fack) n_pulse++;
            if (ic_ack || dc_ack) n_bad_ack++;
        end
        chk("seq flush_ack cycle", 32'(first_ack), 32'd5);
        chk("seq flush_ack pulses", 32'(n_pulse), 32'd1);
        chk("seq acks while flushing", 32'(n_bad_ack), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        rv    = 1'b0;
        #1 chk("seq ack after flush low", dc_ack, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
